hs_resp_fifo: RTL and testbench

Responder-side elastic buffer for the req/ack dataflow fabric. It pulls tokens from an upstream responder by issuing requests and captures the acknowledged data into a FIFO. It then serves downstream requesters by answering their requests with a one-cycle acknowledge pulse and data. It sits between an operator output and a consumer, or between two operators, to absorb rate mismatch and to decouple the operators' request/acknowledge chains.

---
 rtl/hs_resp_fifo_if.sv | 39 +++
 rtl/hs_resp_fifo.sv | 130 +++++++++++++
 tb/tb_hs_resp_fifo.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_resp_fifo_if.sv
// Handshake bundle for hs_resp_fifo: upstream fill req/ack, downstream service req/ack, status.
// The FIFO connects through the slave modport; whatever drives it uses the master modport.
interface hs_resp_fifo_if #(
  parameter int data_width = 32,
  parameter int depth      = 4
);
  localparam int addr_width = $clog2(depth);

  logic                  req_l;
  logic                  ack_l;
  logic [data_width-1:0] din;
  logic                  req_r;
  logic                  ack_r;
  logic [data_width-1:0] dout;
  logic [addr_width:0]   level;
  logic [31:0]           count;

  modport slave (
    output req_l,
    input  ack_l,
    input  din,
    input  req_r,
    output ack_r,
    output dout,
    output level,
    output count
  );

  modport master (
    input  req_l,
    output ack_l,
    output din,
    output req_r,
    input  ack_r,
    input  dout,
    input  level,
    input  count
  );
endinterface

// File: rtl/hs_resp_fifo.sv
// Responder-side elastic buffer: pulls tokens upstream via req_l/ack_l and serves them downstream
// with one-cycle ack_r pulses. Define HS_RESP_FIFO_BYPASS_EN to forward din straight to dout when empty.
module hs_resp_fifo #(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  hs_resp_fifo_if.slave bus
);
  localparam int addr_width = $clog2(depth);
  localparam logic [addr_width:0] FullLevel = depth[addr_width:0];

  typedef enum logic [0:0] {
    UP_IDLE,
    UP_REQ
  } upState_e;

  upState_e              upState_q, upState_d;
  logic [addr_width-1:0] wrPtr_q, wrPtr_d;
  logic [addr_width-1:0] rdPtr_q, rdPtr_d;
  logic [addr_width:0]   level_q, level_d;
  logic [31:0]           count_q, count_d;
  logic                  ackR_q, ackR_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic [data_width-1:0] mem_q [depth];

  logic accept;
  logic bypass;
  logic doWrite;
  logic doRead;
  logic isFull;
  logic isEmpty;

  assign isFull  = (level_q == FullLevel);
  assign isEmpty = (level_q == '0);

  // An acknowledge only counts while our request is outstanding; a stray ack_l is dropped.
  assign accept = (upState_q == UP_REQ) && bus.ack_l && !isFull;

`ifdef HS_RESP_FIFO_BYPASS_EN
  assign bypass = accept && bus.req_r && !ackR_q && isEmpty;
`else
  assign bypass = 1'b0;
`endif

  assign doWrite = accept && !bypass;
  assign doRead  = bus.req_r && !ackR_q && !isEmpty;

  always_comb begin
    upState_d = upState_q;
    case (upState_q)
      UP_IDLE: begin
        if (!bus.ack_l && !isFull) begin
          upState_d = UP_REQ;
        end
      end
      UP_REQ: begin
        if (accept) begin
          upState_d = UP_IDLE;
        end
      end
      default: upState_d = UP_IDLE;
    endcase
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    count_d = count_q;
    ackR_d  = 1'b0;
    dout_d  = dout_q;

    if (doWrite) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end

    if (bypass) begin
      ackR_d  = 1'b1;
      dout_d  = bus.din;
      count_d = count_q + 32'd1;
    end else if (doRead) begin
      ackR_d  = 1'b1;
      dout_d  = mem_q[rdPtr_q];
      rdPtr_d = rdPtr_q + 1'b1;
      count_d = count_q + 32'd1;
    end

    // Simultaneous write and read leaves occupancy untouched.
    if (doWrite && !doRead) begin
      level_d = level_q + 1'b1;
    end else if (!doWrite && doRead) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      upState_q <= UP_IDLE;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      level_q   <= '0;
      count_q   <= '0;
      ackR_q    <= 1'b0;
      dout_q    <= '0;
    end else begin
      upState_q <= upState_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      level_q   <= level_d;
      count_q   <= count_d;
      ackR_q    <= ackR_d;
      dout_q    <= dout_d;
    end
  end

  // Storage carries no reset; only the pointers and level decide what is valid.
  always_ff @(posedge clk_i) begin
    if (doWrite) begin
      mem_q[wrPtr_q] <= bus.din;
    end
  end

  assign bus.req_l = (upState_q == UP_REQ);
  assign bus.ack_r = ackR_q;
  assign bus.dout  = dout_q;
  assign bus.level = level_q;
  assign bus.count = count_q;
endmodule

// File: tb/tb_hs_resp_fifo.sv
// Self-checking bench for hs_resp_fifo: table-driven fill/drain vectors, hand-written corner cases,
// and randomized traffic checked against a queue-based reference model.
module tb_hs_resp_fifo;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  hs_resp_fifo_if #(.data_width(32), .depth(DEPTH)) bus ();

  hs_resp_fifo #(.data_width(32), .depth(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: token queue plus the externally visible handshake state.
  logic [31:0] mq[$];
  bit          mReqL;
  bit          mAckR;
  logic [31:0] mDout;
  logic [31:0] mCount;
  bit          prevAckR;

  typedef struct {
    bit          ackL;
    logic [31:0] din;
    bit          reqR;
    bit          eReqL;
    bit          eAckR;
    logic [31:0] eDout;
    int          eLevel;
    logic [31:0] eCount;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mq.delete();
    mReqL    = 1'b0;
    mAckR    = 1'b0;
    mDout    = '0;
    mCount   = '0;
    prevAckR = 1'b0;
  endfunction

  function automatic void modelStep(input bit a, input logic [31:0] d, input bit r);
    int sizeBefore = mq.size();
    bit took       = mReqL && a && (sizeBefore < DEPTH);
    bit store      = took;
    bit serve      = r && !mAckR;
    bit delivered  = 1'b0;
`ifdef HS_RESP_FIFO_BYPASS_EN
    if (took && serve && sizeBefore == 0) begin
      mDout     = d;
      delivered = 1'b1;
      store     = 1'b0;
    end
`endif
    if (!delivered && serve && sizeBefore > 0) begin
      mDout     = mq.pop_front();
      delivered = 1'b1;
    end
    if (store) mq.push_back(d);
    if (delivered) mCount = mCount + 32'd1;
    mAckR = delivered;
    mReqL = mReqL ? !took : (!a && sizeBefore < DEPTH);
  endfunction

  task automatic checkOutput();
    check("req_l", bus.req_l, mReqL);
    check("ack_r", bus.ack_r, mAckR);
    check("dout", bus.dout, mDout);
    check("level", bus.level, mq.size());
    check("count", bus.count, mCount);
    check("ack_r_twice", bus.ack_r & prevAckR, 0);
    check("level_bound", bus.level > DEPTH, 0);
    prevAckR = bus.ack_r;
  endtask

  // Called at a falling edge: drive, let one rising edge pass, then compare at the next falling edge.
  task automatic applyStimulus(input bit a, input logic [31:0] d, input bit r);
    bus.ack_l = a;
    bus.din   = d;
    bus.req_r = r;
    @(posedge clk);
    if (!rst_n) modelReset();
    else modelStep(a, d, r);
    @(negedge clk);
    checkOutput();
    check("ack_r_without_req", bus.ack_r & !r, 0);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    modelReset();
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0);
  endtask

  int  tok;
  int  nextOut;
  bit  a;
  bit  r;
  int  guard;

  initial begin
    rst_n     = 1'b0;
    bus.ack_l = 1'b0;
    bus.din   = '0;
    bus.req_r = 1'b0;
    modelReset();

    vecs[0]  = '{1, 32'd10,    0, 0, 0, 32'd0,  1, 32'd0};
    vecs[1]  = '{0, 32'd0,     0, 1, 0, 32'd0,  1, 32'd0};
    vecs[2]  = '{1, 32'd11,    0, 0, 0, 32'd0,  2, 32'd0};
    vecs[3]  = '{0, 32'd0,     0, 1, 0, 32'd0,  2, 32'd0};
    vecs[4]  = '{1, 32'd12,    0, 0, 0, 32'd0,  3, 32'd0};
    vecs[5]  = '{0, 32'd0,     0, 1, 0, 32'd0,  3, 32'd0};
    vecs[6]  = '{1, 32'd13,    0, 0, 0, 32'd0,  4, 32'd0};
    vecs[7]  = '{0, 32'd0,     0, 0, 0, 32'd0,  4, 32'd0};
    vecs[8]  = '{0, 32'd0,     0, 0, 0, 32'd0,  4, 32'd0};
    vecs[9]  = '{1, 32'hDEAD,  0, 0, 0, 32'd0,  4, 32'd0};
    vecs[10] = '{0, 32'd0,     1, 0, 1, 32'd10, 3, 32'd1};
    vecs[11] = '{0, 32'd0,     1, 1, 0, 32'd10, 3, 32'd1};
    vecs[12] = '{0, 32'd0,     1, 1, 1, 32'd11, 2, 32'd2};
    vecs[13] = '{0, 32'd0,     1, 1, 0, 32'd11, 2, 32'd2};
    vecs[14] = '{0, 32'd0,     1, 1, 1, 32'd12, 1, 32'd3};
    vecs[15] = '{0, 32'd0,     1, 1, 0, 32'd12, 1, 32'd3};
    vecs[16] = '{0, 32'd0,     1, 1, 1, 32'd13, 0, 32'd4};
    vecs[17] = '{0, 32'd0,     1, 1, 0, 32'd13, 0, 32'd4};

    // Reset hold with ack_l toggling, then release.
    #1;
    checkOutput();
    @(negedge clk);
    for (int i = 0; i < 3; i++) applyStimulus(bit'(i % 2), 32'h1234 + i, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0);
    check("reset_exit_req_l", bus.req_l, 1);

    // Fill to full, a stray ack while full, then drain on alternate cycles.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].ackL, vecs[i].din, vecs[i].reqR);
      check($sformatf("vec%0d_req_l", i), bus.req_l, vecs[i].eReqL);
      check($sformatf("vec%0d_ack_r", i), bus.ack_r, vecs[i].eAckR);
      check($sformatf("vec%0d_dout", i), bus.dout, vecs[i].eDout);
      check($sformatf("vec%0d_level", i), bus.level, vecs[i].eLevel);
      check($sformatf("vec%0d_count", i), bus.count, vecs[i].eCount);
    end

    // Random back-pressure at 50% duty with a lazy upstream responder.
    for (int i = 0; i < 600; i++) begin
      a = bus.req_l && ($urandom_range(2) != 0);
      r = bit'($urandom_range(1));
      applyStimulus(a, $urandom, r);
    end

    // Async reset mid-operation clears everything at once; an ack on the first edge is ignored.
    for (int i = 0; i < 3; i++) applyStimulus(bus.req_l, $urandom, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_req_l", bus.req_l, 0);
    check("midreset_ack_r", bus.ack_r, 0);
    check("midreset_dout", bus.dout, 0);
    check("midreset_level", bus.level, 0);
    check("midreset_count", bus.count, 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 32'h77, 0);
    check("post_reset_ack_ignored_req_l", bus.req_l, 0);
    check("post_reset_ack_ignored_level", bus.level, 0);
    applyStimulus(0, 0, 0);
    check("post_reset_req_l", bus.req_l, 1);

    // Simultaneous read/write around level 2 until the pointers wrap several times.
    guard = 0;
    while (mq.size() < 2 && guard < 20) begin
      applyStimulus(bus.req_l, $urandom, 0);
      guard++;
    end
    check("rw_fill_timeout", guard < 20, 1);
    for (int i = 0; i < 80; i++) applyStimulus(bus.req_l, $urandom, 1);

    // Empty-path latency with a single 0xA5 token.
    guard = 0;
    while ((mq.size() != 0 || mAckR) && guard < 40) begin
      applyStimulus(0, 0, 1);
      guard++;
    end
    check("drain_timeout", guard < 40, 1);
    applyStimulus(0, 0, 0);
    check("lat_pre_level", bus.level, 0);
    check("lat_pre_req_l", bus.req_l, 1);
    applyStimulus(1, 32'hA5, 1);
`ifdef HS_RESP_FIFO_BYPASS_EN
    check("lat_bypass_ack_r", bus.ack_r, 1);
    check("lat_bypass_dout", bus.dout, 32'hA5);
    check("lat_bypass_level", bus.level, 0);
`else
    check("lat_edge_n_ack_r", bus.ack_r, 0);
    check("lat_edge_n_level", bus.level, 1);
    applyStimulus(0, 0, 1);
    check("lat_edge_n1_ack_r", bus.ack_r, 1);
    check("lat_edge_n1_dout", bus.dout, 32'hA5);
    check("lat_edge_n1_level", bus.level, 0);
`endif

    // Streaming 5000 counting tokens with req_r held high.
    resetDut();
    tok     = 0;
    nextOut = 0;
    for (int cyc = 0; cyc < 15000 && nextOut < 5000; cyc++) begin
      a = bus.req_l && (tok < 5000);
      applyStimulus(a, 32'(tok), 1);
      if (a) tok++;
      if (bus.ack_r) begin
        check("stream_order", bus.dout, nextOut);
        nextOut++;
      end
    end
    check("stream_delivered", nextOut, 5000);
    check("stream_count", bus.count, 5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
